fma_operand_unpack: RTL
=======================

// Module: fma_operand_unpack
// PURPOSE
//  Front-end operand decoder for the single-precision fused multiply-add datapath (result = B*C + A).
//  Accepts three raw IEEE-754 binary32 words and a rounding mode through a valid/ready handshake.
//  Produces the unpacked sign/exponent/mantissa fields, operand classes and early special-case flags
//  that the normalize-and-round back end consumes.
//  Two-stage elastic pipeline: S1 captures the raw inputs, S2 holds the decoded results.
// PARAMETERS
//  PARM_EXP   8    exponent field width
//  PARM_MANT  23   stored fraction width; unpacked mantissa is PARM_MANT+1 bits wide
//  PARM_RM    3    rounding-mode width; legal codes 3'b000..3'b100 (RNE,RTZ,RDN,RUP,RMM)
//  PARM_LZ    5    leading-zero-count width; must satisfy 2**PARM_LZ > PARM_MANT+1
// PORTS
//  Clk_i            in   1        clock; all state updates on the rising edge
//  Rst_n_i          in   1        asynchronous reset, active low
//  Flush_i          in   1        synchronous flush; clears both stage valids
//  In_valid_i       in   1        input operands valid
//  In_ready_o       out  1        block can accept an operand set this cycle
//  A_i/B_i/C_i      in   32 each  raw binary32 words: addend A, multiplicands B and C
//  Rounding_mode_i  in   PARM_RM  rounding mode travelling with the operands
//  Out_valid_o      out  1        decoded set valid (S2 occupied)
//  Out_ready_i      in   1        downstream accepts the decoded set
//  X_Sign_o         out  1        X in {A,B,C}: sign bit
//  X_Exp_raw_o      out  PARM_EXP biased exponent field, unchanged
//  X_Mant_o         out  24       {hidden,fraction}; hidden = (exp!=0)
//  X_Lz_o           out  PARM_LZ  leading zeros of X_Mant_o (0 for normals, 24 for zero)
//  X_DeN_o/X_Inf_o/X_Zero_o/X_NaN_o/X_SNaN_o  out 1 each  operand class flags
//  Sub_Sign_o       out  1        effective subtraction = A_sign ^ B_sign ^ C_sign
//  Rounding_mode_o  out  PARM_RM  rounding mode forwarded from S1
//  Invalid_o        out  1        NV: any SNaN | (Inf*Zero) | (B*C = Inf, A = Inf, effective sub) | illegal RM
//  Special_o        out  1        result fully decided here (any NaN, any Inf, or Invalid_o)
// BEHAVIOUR
//  Reset (async, Rst_n_i=0): S1/S2 valids = 0, every output register = 0, In_ready_o = 1.
//  Handshake:
//   - A transfer happens when valid & ready are both high at the clock edge.
//   - Once raised, Out_valid_o and all S2 data stay stable until Out_ready_i is sampled high.
//   - In_valid_i must not depend on In_ready_o.
//  Pipeline advance:
//   - s2_take = !S2_valid | Out_ready_i.
//   - S1 -> S2 transfer when S1_valid & s2_take.
//   - In_ready_o = !S1_valid | s2_take (combinational).
//  Latency: 2 cycles from input accept to Out_valid_o with no backpressure; 1 set/cycle throughput.
//  Full: S1 and S2 both occupied with Out_ready_i = 0 -> In_ready_o = 0; no set is lost or reordered.
//  Simultaneous events: when full and Out_ready_i = 1, S2 loads from S1 and S1 loads a new
//   input in the same cycle.
//  Decode (combinational on S1, registered into S2):
//   - exp==0, frac==0: Zero
//   - exp==0, frac!=0: DeN; hidden = 0; Lz = clz(24-bit mantissa)
//   - exp==all-ones, frac==0: Inf
//   - exp==all-ones, frac!=0: NaN; SNaN when frac MSB = 0
//  Classes are one-hot per operand, except that SNaN implies NaN.
//  Invalid_o terms:
//   - Inf*Zero means (B_Inf & C_Zero) | (B_Zero & C_Inf).
//   - The Inf-Inf term requires (B_Inf|C_Inf) & A_Inf & Sub_Sign & neither B nor C zero.
//   - RM codes 5..7 also set Invalid_o.
//  Flush_i: valids cleared next edge and data registers hold; any input accepted in the flush
//   cycle is discarded. Flush_i has priority over all handshakes.
//  Reset mid-operation: in-flight sets are dropped; Out_valid_o falls asynchronously.
// TESTING
//  1. A=3F800000 B=40000000 C=C0400000, RM=0 -> Out_valid 2 cycles later; A_Exp_raw=7F
//     A_Mant=800000 A_Lz=0 Sub_Sign=1 Invalid=0 Special=0.
//  2. A=00000001 -> A_DeN=1 A_Mant=000001 A_Lz=23.
//     A=00000000 -> A_Zero=1 A_Lz=24.
//  3. B=7F800000 C=00000000 -> Invalid=1 Special=1.
//     A=7F800001 -> A_NaN=A_SNaN=1 Invalid=1.
//     A=7FC00000 -> A_NaN=1 A_SNaN=0 Invalid=0 Special=1.
//  4. A=FF800000 B=7F800000 C=3F800000 -> Sub_Sign=1 Invalid=1.
//     Same with A=7F800000 -> Invalid=0 Special=1.
//     RM=3'b101 with normal operands -> Invalid=1.
//  5. Backpressure:
//     - Out_ready_i=0 for 6 cycles while 4 sets are offered back-to-back.
//     - Expected: exactly 2 accepted and In_ready_o=0 after that; S2 data stable throughout.
//     - On Out_ready_i=1 all 4 sets emerge in order, one per cycle.
//  6. Rst_n_i pulsed low with both stages full -> Out_valid_o=0 immediately, In_ready_o=1.
//     Flush_i for 1 cycle while full -> Out_valid_o=0 next cycle, no stale set emitted.

Source files
------------

// File: rtl/fma_operand_unpack.sv
// Operand decoder in front of the single-precision FMA (B*C + A). Two-stage elastic pipe:
// S1 holds the raw words and S2 holds the unpacked fields, class flags and early exception flags.
module fma_operand_unpack #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3,
    parameter int PARM_LZ   = 5
) (
    input  logic                   Clk_i,
    input  logic                   Rst_n_i,
    input  logic                   Flush_i,
    input  logic                   In_valid_i,
    output logic                   In_ready_o,
    input  logic [PARM_EXP+PARM_MANT:0] A_i,
    input  logic [PARM_EXP+PARM_MANT:0] B_i,
    input  logic [PARM_EXP+PARM_MANT:0] C_i,
    input  logic [PARM_RM-1:0]     Rounding_mode_i,
    output logic                   Out_valid_o,
    input  logic                   Out_ready_i,
    output logic                   A_Sign_o,
    output logic [PARM_EXP-1:0]    A_Exp_raw_o,
    output logic [PARM_MANT:0]     A_Mant_o,
    output logic [PARM_LZ-1:0]     A_Lz_o,
    output logic                   A_DeN_o,
    output logic                   A_Inf_o,
    output logic                   A_Zero_o,
    output logic                   A_NaN_o,
    output logic                   A_SNaN_o,
    output logic                   B_Sign_o,
    output logic [PARM_EXP-1:0]    B_Exp_raw_o,
    output logic [PARM_MANT:0]     B_Mant_o,
    output logic [PARM_LZ-1:0]     B_Lz_o,
    output logic                   B_DeN_o,
    output logic                   B_Inf_o,
    output logic                   B_Zero_o,
    output logic                   B_NaN_o,
    output logic                   B_SNaN_o,
    output logic                   C_Sign_o,
    output logic [PARM_EXP-1:0]    C_Exp_raw_o,
    output logic [PARM_MANT:0]     C_Mant_o,
    output logic [PARM_LZ-1:0]     C_Lz_o,
    output logic                   C_DeN_o,
    output logic                   C_Inf_o,
    output logic                   C_Zero_o,
    output logic                   C_NaN_o,
    output logic                   C_SNaN_o,
    output logic                   Sub_Sign_o,
    output logic [PARM_RM-1:0]     Rounding_mode_o,
    output logic                   Invalid_o,
    output logic                   Special_o
);

    localparam int W  = PARM_EXP + PARM_MANT + 1;
    localparam int MW = PARM_MANT + 1;

    typedef struct packed {
        logic                sign;
        logic [PARM_EXP-1:0] exp;
        logic [MW-1:0]       mant;
        logic [PARM_LZ-1:0]  lz;
        logic                den;
        logic                inf;
        logic                zero;
        logic                nan;
        logic                snan;
    } op_t;

    // Ascending scan so the highest set bit is the last one to write the result.
    function automatic logic [PARM_LZ-1:0] clz(input logic [MW-1:0] m);
        logic [PARM_LZ-1:0] n;
        n = PARM_LZ'(MW);
        for (int i = 0; i < MW; i++)
            if (m[i]) n = PARM_LZ'(MW - 1 - i);
        return n;
    endfunction

    function automatic op_t unpack(input logic [W-1:0] w);
        op_t                  o;
        logic [PARM_EXP-1:0]  e;
        logic [PARM_MANT-1:0] f;
        e      = w[W-2 -: PARM_EXP];
        f      = w[PARM_MANT-1:0];
        o.sign = w[W-1];
        o.exp  = e;
        o.mant = {|e, f};
        o.zero = (e == '0) && (f == '0);
        o.den  = (e == '0) && (f != '0);
        o.inf  = (&e) && (f == '0);
        o.nan  = (&e) && (f != '0);
        o.snan = o.nan && !f[PARM_MANT-1];
        o.lz   = clz(o.mant);
        return o;
    endfunction

    logic               s1_valid, s2_valid;
    logic [W-1:0]       s1_a, s1_b, s1_c;
    logic [PARM_RM-1:0] s1_rm;
    op_t                s2_a, s2_b, s2_c;
    logic               s2_sub, s2_inv, s2_spec;
    logic [PARM_RM-1:0] s2_rm;

    logic s2_take, s1_load, s1_move;
    op_t  d_a, d_b, d_c;
    logic d_sub, d_inv, d_spec;

    assign s2_take    = !s2_valid || Out_ready_i;
    assign In_ready_o = !s1_valid || s2_take;
    assign s1_load    = In_valid_i && In_ready_o;
    assign s1_move    = s1_valid && s2_take;

    always_comb begin
        d_a   = unpack(s1_a);
        d_b   = unpack(s1_b);
        d_c   = unpack(s1_c);
        d_sub = d_a.sign ^ d_b.sign ^ d_c.sign;
        // Inf - Inf only counts when the product really is infinite (no Inf*0 operand).
        d_inv = d_a.snan || d_b.snan || d_c.snan
             || (d_b.inf && d_c.zero) || (d_b.zero && d_c.inf)
             || ((d_b.inf || d_c.inf) && d_a.inf && d_sub && !d_b.zero && !d_c.zero)
             || (s1_rm > PARM_RM'(4));
        d_spec = d_inv || d_a.nan || d_b.nan || d_c.nan || d_a.inf || d_b.inf || d_c.inf;
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_rm    <= '0;
        end else if (Flush_i) begin
            s1_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a     <= A_i;
                s1_b     <= B_i;
                s1_c     <= C_i;
                s1_rm    <= Rounding_mode_i;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_c     <= '0;
            s2_sub   <= 1'b0;
            s2_inv   <= 1'b0;
            s2_spec  <= 1'b0;
            s2_rm    <= '0;
        end else if (Flush_i) begin
            s2_valid <= 1'b0;
        end else if (s2_take) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a    <= d_a;
                s2_b    <= d_b;
                s2_c    <= d_c;
                s2_sub  <= d_sub;
                s2_inv  <= d_inv;
                s2_spec <= d_spec;
                s2_rm   <= s1_rm;
            end
        end
    end

    assign Out_valid_o     = s2_valid;
    assign Sub_Sign_o      = s2_sub;
    assign Invalid_o       = s2_inv;
    assign Special_o       = s2_spec;
    assign Rounding_mode_o = s2_rm;

    assign {A_Sign_o, A_Exp_raw_o, A_Mant_o, A_Lz_o, A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o, A_SNaN_o} = s2_a;
    assign {B_Sign_o, B_Exp_raw_o, B_Mant_o, B_Lz_o, B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o, B_SNaN_o} = s2_b;
    assign {C_Sign_o, C_Exp_raw_o, C_Mant_o, C_Lz_o, C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o, C_SNaN_o} = s2_c;

endmodule
